// File: rtl/lsq_param.sv
// Load/store queue: holds memory ops in program order, captures operands from
// the CDBs, issues loads speculatively and stores only once the ROB commits
// them, and drives a request-hold memory handshake.
module lsq_param #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       in_rollback,
    input  logic                       in_enq,
    input  logic [TAG_W-1:0]           in_enq_tag,
    input  logic                       in_enq_store,
    input  logic [2:0]                 in_enq_funct3,
    output logic                       out_full,
    input  logic [NUM_CDB*TAG_W-1:0]   in_cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    in_cdb_addr,
    input  logic [NUM_CDB*XLEN-1:0]    in_cdb_data,
    input  logic [TAG_W-1:0]           in_commit_tag,
    output logic                       out_mem_ena,
    output logic                       out_mem_iswrite,
    output logic [XLEN-1:0]            out_mem_addr,
    output logic [XLEN-1:0]            out_mem_write_data,
    output logic [2:0]                 out_mem_size,
    input  logic                       in_mem_ready,
    input  logic [XLEN-1:0]            in_mem_read_data,
    output logic                       out_valid,
    output logic [TAG_W-1:0]           out_rob_tag,
    output logic [XLEN-1:0]            out_result
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_KILL} state_t;

    // Transfer size in bytes from the RISC-V width field.
    function automatic logic [2:0] mem_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Sign/zero extension of the returned word according to the load type.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] d);
        case (f3)
            3'b000:  return {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  return {{(XLEN-16){d[15]}}, d[15:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // An index is occupied when its distance from head is below the count.
    function automatic logic occupied(input logic [PTR_W-1:0] idx,
                                      input logic [PTR_W-1:0] head,
                                      input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = idx - head;
        return {1'b0, off} < cnt;
    endfunction

    // Control state
    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d, ncommit_q, ncommit_d;
    logic               full_q, full_d;
    logic [DEPTH-1:0]   valid_q, valid_d, committed_q, committed_d;

    // Entry payload
    logic [TAG_W-1:0]   tag_q    [DEPTH];
    logic [TAG_W-1:0]   tag_d    [DEPTH];
    logic [2:0]         funct3_q [DEPTH];
    logic [2:0]         funct3_d [DEPTH];
    logic [XLEN-1:0]    addr_q   [DEPTH];
    logic [XLEN-1:0]    addr_d   [DEPTH];
    logic [XLEN-1:0]    data_q   [DEPTH];
    logic [XLEN-1:0]    data_d   [DEPTH];
    logic [DEPTH-1:0]   store_q, store_d;

    // Memory request and in-flight load bookkeeping
    logic               mem_ena_q, mem_ena_d, mem_wr_q, mem_wr_d;
    logic [XLEN-1:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [2:0]         mem_size_q, mem_size_d;
    logic [TAG_W-1:0]   iss_tag_q, iss_tag_d;
    logic [2:0]         iss_f3_q, iss_f3_d;

    // Load result pulse
    logic               res_vld_q, res_vld_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [XLEN-1:0]    res_q, res_d;

    logic               do_enq, do_issue, commit_store;
    logic [CNT_W-1:0]   ncommit_nxt;

    // Next-state logic: capture, commit, issue FSM, enqueue, rollback.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ncommit_d    = ncommit_q;
        full_d       = full_q;
        valid_d      = valid_q;
        committed_d  = committed_q;
        tag_d        = tag_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        data_d       = data_q;
        store_d      = store_q;
        mem_ena_d    = mem_ena_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        iss_tag_d    = iss_tag_q;
        iss_f3_d     = iss_f3_q;
        res_vld_d    = 1'b0;
        res_tag_d    = '0;
        res_d        = '0;
        do_enq       = 1'b0;
        do_issue     = 1'b0;
        commit_store = 1'b0;
        ncommit_nxt  = ncommit_q;

        if (ena) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occupied(PTR_W'(i), head_q, count_q)) begin
                    if (!committed_q[i]) begin
                        for (int p = 0; p < NUM_CDB; p++) begin
                            if (in_cdb_tag[p*TAG_W +: TAG_W] != '0 &&
                                tag_q[i] == in_cdb_tag[p*TAG_W +: TAG_W]) begin
                                addr_d[i]  = in_cdb_addr[p*XLEN +: XLEN];
                                data_d[i]  = in_cdb_data[p*XLEN +: XLEN];
                                valid_d[i] = 1'b1;
                            end
                        end
                    end
                    if (in_commit_tag != '0 && tag_q[i] == in_commit_tag) begin
                        committed_d[i] = 1'b1;
                        if (store_q[i] && !committed_q[i]) begin
                            commit_store = 1'b1;
                        end
                    end
                end
            end
            ncommit_nxt = ncommit_q + CNT_W'(commit_store);

            case (state_q)
                S_IDLE: begin
                    if (!in_rollback && count_q != '0 && valid_q[head_q] &&
                        (!store_q[head_q] || committed_q[head_q])) begin
                        do_issue = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_mem_ready) begin
                        mem_ena_d = 1'b0;
                        state_d   = S_IDLE;
                        if (!in_rollback) begin
                            res_vld_d = 1'b1;
                            res_tag_d = iss_tag_q;
                            res_d     = load_extend(iss_f3_q, in_mem_read_data);
                        end
                    end else if (in_rollback) begin
                        state_d = S_KILL;
                    end
                end
                default: begin
                    // STORE and KILL both just wait out the handshake.
                    if (in_mem_ready) begin
                        mem_ena_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            endcase

            if (do_issue) begin
                mem_ena_d   = 1'b1;
                mem_wr_d    = store_q[head_q];
                mem_addr_d  = addr_q[head_q];
                mem_wdata_d = data_q[head_q];
                mem_size_d  = mem_size(funct3_q[head_q]);
                iss_tag_d   = tag_q[head_q];
                iss_f3_d    = funct3_q[head_q];
                state_d     = store_q[head_q] ? S_STORE : S_LOAD;
                valid_d[head_q]     = 1'b0;
                committed_d[head_q] = 1'b0;
                head_d      = head_q + 1'b1;
                if (store_q[head_q]) begin
                    ncommit_nxt = ncommit_nxt - 1'b1;
                end
            end

            do_enq = in_enq && !full_q && !in_rollback;
            if (do_enq) begin
                tag_d[tail_q]       = in_enq_tag;
                store_d[tail_q]     = in_enq_store;
                funct3_d[tail_q]    = in_enq_funct3;
                valid_d[tail_q]     = 1'b0;
                committed_d[tail_q] = 1'b0;
                tail_d              = tail_q + 1'b1;
            end

            count_d   = count_q + CNT_W'(do_enq) - CNT_W'(do_issue);
            ncommit_d = ncommit_nxt;

            // Rollback keeps only the committed stores at the front of the queue.
            if (in_rollback) begin
                tail_d  = head_q + ncommit_nxt[PTR_W-1:0];
                count_d = ncommit_nxt;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!committed_d[i]) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end

            full_d = (count_d == CNT_W'(DEPTH));
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ncommit_q   <= '0;
            full_q      <= 1'b0;
            valid_q     <= '0;
            committed_q <= '0;
            mem_ena_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            iss_tag_q   <= '0;
            iss_f3_q    <= '0;
            res_vld_q   <= 1'b0;
            res_tag_q   <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ncommit_q   <= ncommit_d;
            full_q      <= full_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            mem_ena_q   <= mem_ena_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            iss_tag_q   <= iss_tag_d;
            iss_f3_q    <= iss_f3_d;
            res_vld_q   <= res_vld_d;
            res_tag_q   <= res_tag_d;
            res_q       <= res_d;
        end
    end

    // Entry payload needs no reset: it is only read once occupied and valid.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        store_q  <= store_d;
    end

    assign out_full           = full_q;
    assign out_mem_ena        = mem_ena_q;
    assign out_mem_iswrite    = mem_wr_q;
    assign out_mem_addr       = mem_addr_q;
    assign out_mem_write_data = mem_wdata_q;
    assign out_mem_size       = mem_size_q;
    assign out_valid          = res_vld_q;
    assign out_rob_tag        = res_tag_q;
    assign out_result         = res_q;

endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: load extension, store commit gating, full
// handling with pointer wrap, rollback with committed stores, in-flight kill.
module tb_lsq_param;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        in_rollback;
    logic        in_enq;
    logic [3:0]  in_enq_tag;
    logic        in_enq_store;
    logic [2:0]  in_enq_funct3;
    logic        out_full;
    logic [7:0]  in_cdb_tag;
    logic [63:0] in_cdb_addr;
    logic [63:0] in_cdb_data;
    logic [3:0]  in_commit_tag;
    logic        out_mem_ena;
    logic        out_mem_iswrite;
    logic [31:0] out_mem_addr;
    logic [31:0] out_mem_write_data;
    logic [2:0]  out_mem_size;
    logic        in_mem_ready;
    logic [31:0] in_mem_read_data;
    logic        out_valid;
    logic [3:0]  out_rob_tag;
    logic [31:0] out_result;

    int checks   = 0;
    int failures = 0;

    lsq_param #(.DEPTH(16), .TAG_W(4), .XLEN(32), .NUM_CDB(2)) dut (
        .clk                (clk),
        .rst                (rst),
        .ena                (ena),
        .in_rollback        (in_rollback),
        .in_enq             (in_enq),
        .in_enq_tag         (in_enq_tag),
        .in_enq_store       (in_enq_store),
        .in_enq_funct3      (in_enq_funct3),
        .out_full           (out_full),
        .in_cdb_tag         (in_cdb_tag),
        .in_cdb_addr        (in_cdb_addr),
        .in_cdb_data        (in_cdb_data),
        .in_commit_tag      (in_commit_tag),
        .out_mem_ena        (out_mem_ena),
        .out_mem_iswrite    (out_mem_iswrite),
        .out_mem_addr       (out_mem_addr),
        .out_mem_write_data (out_mem_write_data),
        .out_mem_size       (out_mem_size),
        .in_mem_ready       (in_mem_ready),
        .in_mem_read_data   (in_mem_read_data),
        .out_valid          (out_valid),
        .out_rob_tag        (out_rob_tag),
        .out_result         (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input int p, input logic [3:0] t, input logic [31:0] a,
                           input logic [31:0] d);
        in_cdb_tag[p*4 +: 4]   = t;
        in_cdb_addr[p*32 +: 32] = a;
        in_cdb_data[p*32 +: 32] = d;
    endtask

    task automatic clear_cdb();
        in_cdb_tag  = '0;
        in_cdb_addr = '0;
        in_cdb_data = '0;
    endtask

    task automatic enq(input logic [3:0] t, input logic st, input logic [2:0] f3);
        in_enq        = 1'b1;
        in_enq_tag    = t;
        in_enq_store  = st;
        in_enq_funct3 = f3;
        tick();
        in_enq = 1'b0;
    endtask

    task automatic mem_ready(input logic [31:0] rdata);
        in_mem_ready     = 1'b1;
        in_mem_read_data = rdata;
        tick();
        in_mem_ready     = 1'b0;
        in_mem_read_data = '0;
    endtask

    // One load end to end: enqueue, CDB fill, issue, completion pulse.
    task automatic run_load(input logic [3:0] t, input logic [2:0] f3, input int port,
                            input logic [31:0] a, input logic [31:0] rdata,
                            input logic [2:0] exp_size, input logic [31:0] exp_res);
        enq(t, 1'b0, f3);
        set_cdb(port, t, a, 32'h0);
        tick();
        clear_cdb();
        tick();
        check("ld_mem_ena", out_mem_ena, 1);
        check("ld_iswrite", out_mem_iswrite, 0);
        check("ld_addr", out_mem_addr, a);
        check("ld_size", out_mem_size, exp_size);
        mem_ready(rdata);
        check("ld_valid", out_valid, 1);
        check("ld_tag", out_rob_tag, t);
        check("ld_result", out_result, exp_res);
        check("ld_ena_drop", out_mem_ena, 0);
        tick();
        check("ld_valid_clr", out_valid, 0);
        check("ld_tag_clr", out_rob_tag, 0);
        check("ld_result_clr", out_result, 0);
    endtask

    initial begin
        rst              = 1'b0;
        ena              = 1'b1;
        in_rollback      = 1'b0;
        in_enq           = 1'b0;
        in_enq_tag       = '0;
        in_enq_store     = 1'b0;
        in_enq_funct3    = '0;
        in_commit_tag    = '0;
        in_mem_ready     = 1'b0;
        in_mem_read_data = '0;
        clear_cdb();

        // Reset state
        #12;
        check("rst_full", out_full, 0);
        check("rst_mem_ena", out_mem_ena, 0);
        check("rst_addr", out_mem_addr, 0);
        check("rst_size", out_mem_size, 0);
        check("rst_valid", out_valid, 0);
        check("rst_tag", out_rob_tag, 0);
        check("rst_result", out_result, 0);
        tick();
        rst = 1'b1;
        tick();

        // Load extension variants across both CDB ports
        run_load(4'd3, 3'b000, 0, 32'h100, 32'h0000_0080, 3'd1, 32'hFFFF_FF80);
        run_load(4'd3, 3'b100, 1, 32'h104, 32'h0000_0080, 3'd1, 32'h0000_0080);
        run_load(4'd6, 3'b001, 0, 32'h108, 32'h0000_8001, 3'd2, 32'hFFFF_8001);
        run_load(4'd7, 3'b101, 1, 32'h10C, 32'h0000_8001, 3'd2, 32'h0000_8001);
        run_load(4'd8, 3'b010, 0, 32'h110, 32'h1234_5678, 3'd4, 32'h1234_5678);

        // Store waits for commit
        enq(4'd5, 1'b1, 3'b001);
        set_cdb(1, 4'd5, 32'h200, 32'hCAFE_BABE);
        tick();
        clear_cdb();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("st_wait_ena", out_mem_ena, 0);
        end
        in_commit_tag = 4'd5;
        tick();
        in_commit_tag = '0;
        tick();
        check("st_mem_ena", out_mem_ena, 1);
        check("st_iswrite", out_mem_iswrite, 1);
        check("st_addr", out_mem_addr, 32'h200);
        check("st_wdata", out_mem_write_data, 32'hCAFE_BABE);
        check("st_size", out_mem_size, 3'd2);
        mem_ready(32'h0);
        check("st_ena_drop", out_mem_ena, 0);
        check("st_no_valid", out_valid, 0);
        tick();
        check("st_no_valid2", out_valid, 0);

        // Fill to DEPTH, drop extra, pop one, refill across the wrap
        for (int i = 0; i < 16; i++) begin
            in_enq        = 1'b1;
            in_enq_tag    = 4'((i % 15) + 1);
            in_enq_store  = 1'b0;
            in_enq_funct3 = 3'b010;
            tick();
            if (i == 14) check("fill_not_full", out_full, 0);
        end
        check("fill_full", out_full, 1);
        in_enq_tag = 4'd7;
        tick();
        in_enq = 1'b0;
        check("fill_drop_full", out_full, 1);
        set_cdb(0, 4'd1, 32'h300, 32'h0);
        tick();
        clear_cdb();
        tick();
        check("pop_mem_ena", out_mem_ena, 1);
        check("pop_addr", out_mem_addr, 32'h300);
        check("pop_not_full", out_full, 0);
        mem_ready(32'hAABB_CCDD);
        check("pop_valid", out_valid, 1);
        check("pop_tag", out_rob_tag, 4'd1);
        check("pop_result", out_result, 32'hAABB_CCDD);
        enq(4'd9, 1'b0, 3'b010);
        check("wrap_full", out_full, 1);
        in_rollback = 1'b1;
        tick();
        in_rollback = 1'b0;
        check("flush_not_full", out_full, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_idle", out_mem_ena, 0);
        end

        // Rollback keeps committed stores A, B and discards load C
        enq(4'd1, 1'b1, 3'b010);
        enq(4'd2, 1'b1, 3'b000);
        enq(4'd3, 1'b0, 3'b010);
        set_cdb(0, 4'd1, 32'h400, 32'h1111_1111);
        set_cdb(1, 4'd2, 32'h404, 32'h0000_0022);
        tick();
        clear_cdb();
        set_cdb(0, 4'd3, 32'h408, 32'h0);
        tick();
        clear_cdb();
        in_commit_tag = 4'd1;
        tick();
        in_commit_tag = 4'd2;
        in_rollback   = 1'b1;
        tick();
        in_commit_tag = '0;
        in_rollback   = 1'b0;
        check("rb_no_issue", out_mem_ena, 0);
        tick();
        check("rbA_ena", out_mem_ena, 1);
        check("rbA_wr", out_mem_iswrite, 1);
        check("rbA_addr", out_mem_addr, 32'h400);
        check("rbA_data", out_mem_write_data, 32'h1111_1111);
        check("rbA_size", out_mem_size, 3'd4);
        mem_ready(32'h0);
        check("rbA_drop", out_mem_ena, 0);
        tick();
        check("rbB_ena", out_mem_ena, 1);
        check("rbB_wr", out_mem_iswrite, 1);
        check("rbB_addr", out_mem_addr, 32'h404);
        check("rbB_data", out_mem_write_data, 32'h0000_0022);
        check("rbB_size", out_mem_size, 3'd1);
        mem_ready(32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rbC_never", out_mem_ena, 0);
        end

        // Rollback during an in-flight load
        enq(4'd4, 1'b0, 3'b010);
        enq(4'd5, 1'b1, 3'b010);
        set_cdb(0, 4'd4, 32'h500, 32'h0);
        set_cdb(1, 4'd5, 32'h504, 32'hDEAD_BEEF);
        tick();
        clear_cdb();
        in_commit_tag = 4'd5;
        tick();
        in_commit_tag = '0;
        check("kill_ld_ena", out_mem_ena, 1);
        check("kill_ld_wr", out_mem_iswrite, 0);
        check("kill_ld_addr", out_mem_addr, 32'h500);
        in_rollback = 1'b1;
        tick();
        in_rollback = 1'b0;
        check("kill_hold0", out_mem_ena, 1);
        check("kill_hold_addr", out_mem_addr, 32'h500);
        tick();
        check("kill_hold1", out_mem_ena, 1);
        tick();
        check("kill_hold2", out_mem_ena, 1);
        mem_ready(32'h1234_5678);
        check("kill_drop", out_mem_ena, 0);
        check("kill_no_valid", out_valid, 0);
        tick();
        check("kill_no_valid2", out_valid, 0);
        check("kill_st_ena", out_mem_ena, 1);
        check("kill_st_wr", out_mem_iswrite, 1);
        check("kill_st_addr", out_mem_addr, 32'h504);
        check("kill_st_data", out_mem_write_data, 32'hDEAD_BEEF);
        mem_ready(32'h0);
        check("kill_st_drop", out_mem_ena, 0);
        check("kill_st_no_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsq_param.md
Name: lsq_param

Overview:
- Parametrised load/store queue for the out-of-order core. Sits between dispatch, CDB, ROB commit and the data-memory controller.
- Holds memory ops in program order, captures address/data from NUM_CDB broadcast buses, and issues loads speculatively and stores only after ROB commit.
- Compared with the previous generation it adds a full flag, multi-CDB capture, zero-extending LBU/LHU, and a request-hold memory handshake.
- Rollback keeps committed stores and safely discards a load already in flight.

Parameters:
- DEPTH, 16, number of queue entries; power of two, at least 2.
- TAG_W, 4, ROB tag width; tag 0 means "no tag".
- XLEN, 32, address/data width.
- NUM_CDB, 2, number of CDB broadcast ports.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; low freezes all state except reset.
- in_rollback  in  1  misbranch flush.
- in_enq  in  1  enqueue request.
- in_enq_tag  in  TAG_W  ROB tag of the enqueued op.
- in_enq_store  in  1  1 = store, 0 = load.
- in_enq_funct3  in  3  RISC-V funct3.
- out_full  out  1  count == DEPTH (registered).
- in_cdb_tag  in  NUM_CDB*TAG_W  packed CDB tags.
- in_cdb_addr  in  NUM_CDB*XLEN  packed effective addresses.
- in_cdb_data  in  NUM_CDB*XLEN  packed store data.
- in_commit_tag  in  TAG_W  ROB commit tag; 0 = none.
- out_mem_ena  out  1  memory request, held until in_mem_ready.
- out_mem_iswrite  out  1  write request.
- out_mem_addr  out  XLEN  request address.
- out_mem_write_data  out  XLEN  store data.
- out_mem_size  out  3  transfer size: 1, 2 or 4 bytes.
- in_mem_ready  in  1  one-cycle completion pulse.
- in_mem_read_data  in  XLEN  load data, valid with in_mem_ready.
- out_valid  out  1  load-result pulse.
- out_rob_tag  out  TAG_W  result tag; 0 when out_valid is low.
- out_result  out  XLEN  extended load result.

Behaviour:
- **Reset** (rst = 0, asynchronous):
  - head = tail = 0, count = 0, ncommit = 0, state = IDLE.
  - All entry valid/committed bits cleared.
  - All outputs 0.
- **Entry fields:** tag, store, funct3, addr, data, valid, committed. Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- **Enqueue:** occurs when in_enq && !out_full && !in_rollback.
  - Writes the entry at tail with valid = 0 and committed = 0, then increments tail.
  - An enqueue while full is dropped; upstream must gate on out_full.
- **CDB capture:**
  - For each port p and each occupied, uncommitted entry with tag == cdb_tag[p] != 0: latch addr and data, set valid.
  - Two ports never carry the same tag in one cycle.
- **Commit:**
  - An occupied entry with tag == in_commit_tag != 0 sets committed.
  - If that entry is a store, ncommit increments.
  - Commits arrive in order, so committed entries are contiguous from head.
- **Issue:** only when state == IDLE, count != 0, head entry valid, !in_rollback, and the head entry is a load or is committed.
  - Drives the mem outputs from the head entry, pops head, and decrements count.
  - A store issue also decrements ncommit.
  - out_mem_size: funct3[1:0] = 00 gives 1, 01 gives 2, otherwise 4.
  - Next state: STORE or LOAD.
- **STORE/LOAD hold:** mem outputs stay stable and out_mem_ena stays high until in_mem_ready.
  - On ready, out_mem_ena drops and state returns to IDLE. No new issue happens in that same cycle.
- **Load completion:** in the cycle after in_mem_ready, out_valid = 1, out_rob_tag = the issued tag, and out_result is extended by funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other: full word.
  - In every other cycle out_valid = 0, out_rob_tag = 0, out_result = 0.
- **Rollback:**
  - Commit in the same cycle is applied first.
  - tail = head + ncommit_next and count = ncommit_next; uncommitted entries are invalidated.
  - Enqueue and issue are suppressed that cycle.
  - Rollback in LOAD moves to KILL. KILL keeps out_mem_ena high until ready, then returns to IDLE with no out_valid.
  - STORE is unaffected.
- **Simultaneous issue and enqueue:** count is unchanged, and out_full is recomputed from the net count.
- **ena = 0:** freezes everything; the pulse outputs are forced to 0.

Test Plan:
- Enqueue load tag 3 with funct3 000; CDB0 sends tag 3, addr 0x100. Mem returns 0x80 one cycle later → mem read at 0x100, size 1; next cycle out_valid = 1, tag 3, result 0xFFFFFF80.
- Same sequence with funct3 100 → result 0x00000080.
- Store tag 5 filled via CDB1, no commit, for 10 cycles → out_mem_ena stays 0. Then commit 5 → write addr/data issued, size per funct3, no out_valid.
- Fill DEPTH entries → out_full = 1; an extra enqueue is dropped. Pop one → out_full = 0 and the pointer wraps correctly.
- Queue holds committed store A, committed store B, then load C. Rollback → count = 2; A and B drain in order; C is never issued.
- Load in flight, rollback, then in_mem_ready 3 cycles later → out_mem_ena held until ready, no out_valid, next committed store issues afterwards.
